// File: rtl/uart_pkg.sv
// uart_pkg: shared UART constants and TX arbiter state encoding.
// Imported by uart_tx_arbiter and uart_rr_pick.
package uart_pkg;

  localparam int UART_CLK_PER_BIT = 2604;
  localparam int UART_FRAME_BITS  = 10;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_SEND = 2'd1,
    ARB_WAIT = 2'd2
  } arb_state_t;

  // A watchdog shorter than one frame would abort healthy transfers.
  function automatic bit timeout_fits(input int cycles);
    return cycles > UART_FRAME_BITS * UART_CLK_PER_BIT;
  endfunction

endpackage

// File: rtl/uart_rr_pick.sv
// uart_rr_pick: combinational round-robin picker.
// First set request at or above i_ptr, wrapping; one-hot and index out.
module uart_rr_pick
  import uart_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [IDX_W-1:0]   i_ptr,
  output logic [NUM_REQ-1:0] o_onehot,
  output logic [IDX_W-1:0]   o_idx,
  output logic               o_any
);

  // Scan from the pointer upward, wrapping, and keep the first hit.
  always_comb begin : p_pick
    int j;
    logic [IDX_W-1:0] jj;
    o_onehot = '0;
    o_idx    = '0;
    o_any    = 1'b0;
    j        = 0;
    jj       = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      j  = (int'(i_ptr) + i) % NUM_REQ;
      jj = IDX_W'(j);
      if (!o_any && i_req[jj]) begin
        o_any        = 1'b1;
        o_idx        = jj;
        o_onehot[jj] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin share of one UART TX with a done watchdog.
// Optional UART_ARB_LOCK_EN keeps the grant for multi-byte messages.
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int NUM_REQ        = 4,
  parameter int BUS_WIDTH      = 8,
  parameter int TIMEOUT_CYCLES = 32768
) (
  input  logic                         i_clk,
  input  logic                         i_rst,
  input  logic [NUM_REQ-1:0]           i_req_valid,
  input  logic [NUM_REQ*BUS_WIDTH-1:0] i_req_data,
`ifdef UART_ARB_LOCK_EN
  input  logic [NUM_REQ-1:0]           i_req_lock,
`endif
  output logic [NUM_REQ-1:0]           o_req_ready,
  output logic [NUM_REQ-1:0]           o_grant,
  output logic [BUS_WIDTH-1:0]         o_tx_bus,
  output logic                         o_tx_start,
  input  logic                         i_tx_done,
  output logic                         o_busy,
  output logic                         o_timeout
);

  localparam int IW = $clog2(NUM_REQ);
  localparam int CW = $clog2(TIMEOUT_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(NUM_REQ - 1);

  if (!timeout_fits(TIMEOUT_CYCLES)) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must exceed one UART frame");
  end
  if (NUM_REQ < 2 || NUM_REQ > 16) begin : g_bad_num_req
    $error("NUM_REQ must be in 2..16");
  end

  arb_state_t state_q, state_d;

  logic [IW-1:0]        ptr_q, idx_q, ptr_adv;
  logic [IW-1:0]        pick_idx, win_idx;
  logic [NUM_REQ-1:0]   pick_oh, win_oh;
  logic                 pick_any, win_any;
  logic [BUS_WIDTH-1:0] win_data;
  logic [CW-1:0]        cnt_q;
  logic                 done_ev, tout_ev;
  logic                 lock_hit, lock_set;

  uart_rr_pick #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IW)
  ) u_pick (
    .i_req    (i_req_valid),
    .i_ptr    (ptr_q),
    .o_onehot (pick_oh),
    .o_idx    (pick_idx),
    .o_any    (pick_any)
  );

`ifdef UART_ARB_LOCK_EN
  logic lock_q;

  assign lock_hit = lock_q & i_req_valid[idx_q];
  assign lock_set = i_req_lock[idx_q] & i_req_valid[idx_q];

  // Remember a held grant at done; a watchdog abort always drops it.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      lock_q <= 1'b0;
    end else if (done_ev) begin
      lock_q <= lock_set;
    end else if (tout_ev) begin
      lock_q <= 1'b0;
    end
  end
`else
  assign lock_hit = 1'b0;
  assign lock_set = 1'b0;
`endif

  assign ptr_adv = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;

  // Winner: held owner when locked, otherwise the round-robin pick.
  always_comb begin
    win_idx  = pick_idx;
    win_oh   = pick_oh;
    win_any  = pick_any;
    win_data = '0;
    if (lock_hit) begin
      win_idx        = idx_q;
      win_oh         = '0;
      win_oh[idx_q]  = 1'b1;
      win_any        = 1'b1;
    end
    for (int k = 0; k < NUM_REQ; k++) begin
      if (win_idx == IW'(k)) begin
        win_data = i_req_data[k*BUS_WIDTH +: BUS_WIDTH];
      end
    end
  end

  // Next state; done beats the watchdog in the same cycle.
  always_comb begin
    state_d = state_q;
    done_ev = 1'b0;
    tout_ev = 1'b0;
    unique case (state_q)
      ARB_IDLE: begin
        if (win_any) state_d = ARB_SEND;
      end
      ARB_SEND: begin
        state_d = ARB_WAIT;
      end
      ARB_WAIT: begin
        if (i_tx_done) begin
          done_ev = 1'b1;
          state_d = ARB_IDLE;
        end else if (cnt_q == CNT_LAST) begin
          tout_ev = 1'b1;
          state_d = ARB_IDLE;
        end
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge i_clk) begin
    if (i_rst) state_q <= ARB_IDLE;
    else       state_q <= state_d;
  end

  // Registered outputs, pointer, owner index and watchdog counter.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      ptr_q       <= '0;
      idx_q       <= '0;
      cnt_q       <= '0;
      o_tx_bus    <= '0;
      o_grant     <= '0;
      o_req_ready <= '0;
      o_tx_start  <= 1'b0;
      o_busy      <= 1'b0;
      o_timeout   <= 1'b0;
    end else begin
      o_tx_start  <= 1'b0;
      o_req_ready <= '0;
      o_timeout   <= tout_ev;
      o_busy      <= (state_d != ARB_IDLE);
      if (state_q == ARB_IDLE && win_any) begin
        idx_q       <= win_idx;
        o_grant     <= win_oh;
        o_tx_bus    <= win_data;
        o_tx_start  <= 1'b1;
        o_req_ready <= win_oh;
      end
      if (state_q == ARB_SEND) begin
        cnt_q <= '0;
      end else if (state_q == ARB_WAIT && cnt_q != '1) begin
        cnt_q <= cnt_q + 1'b1;
      end
      if (done_ev || tout_ev) begin
        o_grant <= '0;
        if (!(done_ev && lock_set)) ptr_q <= ptr_adv;
      end
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: scoreboard bench with a queue-based arbitration model.
// Directed reset/timeout/lock cases followed by randomized traffic.
module tb_uart_tx_arbiter;

  localparam int N = 4;
  localparam int W = 8;
  localparam int T = 32768;

  logic         i_clk = 1'b0;
  logic         i_rst = 1'b1;
  logic [N-1:0] i_req_valid = '0;
  logic [N*W-1:0] i_req_data = '0;
`ifdef UART_ARB_LOCK_EN
  logic [N-1:0] i_req_lock = '0;
`endif
  logic         i_tx_done = 1'b0;
  logic [N-1:0] o_req_ready;
  logic [N-1:0] o_grant;
  logic [W-1:0] o_tx_bus;
  logic         o_tx_start;
  logic         o_busy;
  logic         o_timeout;

  typedef struct {
    int           idx;
    logic [W-1:0] data;
  } exp_t;

  exp_t         sbq[$];
  logic [W-1:0] drq[N][$];
  logic [W-1:0] mq[N][$];
  int           mptr  = 0;
  bit           to_ok = 1'b0;
  int           n_chk  = 0;
  int           n_fail = 0;

  uart_tx_arbiter #(
    .NUM_REQ        (N),
    .BUS_WIDTH      (W),
    .TIMEOUT_CYCLES (T)
  ) dut (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_req_valid (i_req_valid),
    .i_req_data  (i_req_data),
`ifdef UART_ARB_LOCK_EN
    .i_req_lock  (i_req_lock),
`endif
    .o_req_ready (o_req_ready),
    .o_grant     (o_grant),
    .o_tx_bus    (o_tx_bus),
    .o_tx_start  (o_tx_start),
    .i_tx_done   (i_tx_done),
    .o_busy      (o_busy),
    .o_timeout   (o_timeout)
  );

  always #5 i_clk = ~i_clk;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic refresh();
    for (int k = 0; k < N; k++) begin
      i_req_valid[k] = (drq[k].size() != 0);
      if (drq[k].size() != 0) i_req_data[k*W +: W] = drq[k][0];
      else                    i_req_data[k*W +: W] = '0;
    end
  endtask

  task automatic add_byte(input int k, input logic [W-1:0] b);
    drq[k].push_back(b);
    mq[k].push_back(b);
    refresh();
  endtask

  // Model: a locked owner with data goes again, else first pending at/after mptr.
  task automatic model_pick(input int lockk, output bit found);
    int k;
    found = 1'b0;
    k = -1;
    if (lockk >= 0 && mq[lockk].size() != 0) begin
      k = lockk;
    end else begin
      for (int i = 0; i < N; i++) begin
        int j;
        j = (mptr + i) % N;
        if (k < 0 && mq[j].size() != 0) k = j;
      end
    end
    if (k >= 0) begin
      exp_t e;
      e.idx  = k;
      e.data = mq[k].pop_front();
      sbq.push_back(e);
      mptr  = (k + 1) % N;
      found = 1'b1;
    end
  endtask

  task automatic kick(input int lockk, output bit found);
    model_pick(lockk, found);
    tick();
    if (found) check("start_latency", 32'(o_tx_start), 32'd1);
  endtask

  task automatic do_done(input int lockk, output bit found);
    model_pick(lockk, found);
    i_tx_done = 1'b1;
    tick();
    i_tx_done = 1'b0;
    check("grant_clear", 32'(o_grant), 32'd0);
    check("busy_clear", 32'(o_busy), 32'd0);
    if (found) begin
      tick();
      check("next_send", 32'(o_tx_start), 32'd1);
    end
  endtask

  // Monitor: every start pulse must match the oldest expected byte.
  initial begin
    exp_t e;
    forever begin
      tick();
      if (o_tx_start) begin
        if (sbq.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL unexpected_start: got grant %b bus %0h, required no start",
                   o_grant, o_tx_bus);
        end else begin
          e = sbq.pop_front();
          check("tx_bus", 32'(o_tx_bus), 32'(e.data));
          check("req_ready", 32'(o_req_ready), 32'd1 << e.idx);
          check("grant", 32'(o_grant), 32'd1 << e.idx);
        end
      end
      if (o_timeout) check("timeout_allowed", 32'(to_ok), 32'd1);
    end
  end

  // Requesters: drop the accepted byte after each ready pulse.
  initial begin
    forever begin
      tick();
      for (int k = 0; k < N; k++) begin
        if (o_req_ready[k] && drq[k].size() != 0) void'(drq[k].pop_front());
      end
      refresh();
    end
  end

  initial begin
    bit found;
    bit active;
    int n;

    repeat (3) tick();
    check("rst_tx_bus", 32'(o_tx_bus), 32'd0);
    check("rst_grant", 32'(o_grant), 32'd0);
    check("rst_ready", 32'(o_req_ready), 32'd0);
    check("rst_start", 32'(o_tx_start), 32'd0);
    check("rst_busy", 32'(o_busy), 32'd0);
    check("rst_timeout", 32'(o_timeout), 32'd0);
    i_rst = 1'b0;
    tick();
    check("idle_after_rst", 32'(o_busy), 32'd0);

    add_byte(2, 8'hA5);
    kick(-1, found);
    tick();
    check("start_one_cycle", 32'(o_tx_start), 32'd0);
    check("ready_one_cycle", 32'(o_req_ready), 32'd0);
    check("grant_held", 32'(o_grant), 32'h4);
    repeat (3) tick();
    do_done(-1, found);

    add_byte(0, 8'($urandom));
    kick(-1, found);
    to_ok = 1'b1;
    n = 0;
    do begin
      tick();
      n++;
    end while (!o_timeout && n < T + 8);
    check("timeout_cycle", 32'(n), 32'(T + 1));
    check("timeout_idle", 32'(o_busy), 32'd0);
    check("timeout_grant", 32'(o_grant), 32'd0);
    tick();
    check("timeout_one_cycle", 32'(o_timeout), 32'd0);
    to_ok = 1'b0;

    add_byte(0, 8'($urandom));
    kick(-1, found);
    for (int c = 0; c < T; c++) tick();
    check("last_count_busy", 32'(o_busy), 32'd1);
    do_done(-1, found);
    check("done_beats_timeout", 32'(o_timeout), 32'd0);
    tick();
    check("no_late_timeout", 32'(o_timeout), 32'd0);

`ifdef UART_ARB_LOCK_EN
    i_req_lock[1] = 1'b1;
    add_byte(1, 8'h11);
    add_byte(1, 8'h22);
    add_byte(1, 8'h33);
    add_byte(0, 8'h44);
    kick(-1, found);
    repeat (3) begin
      tick();
      do_done(1, found);
    end
    tick();
    do_done(1, found);
    i_req_lock[1] = 1'b0;
`endif

    add_byte(2, 8'($urandom));
    kick(-1, found);
    tick();
    tick();
    i_rst = 1'b1;
    tick();
    check("mid_rst_tx_bus", 32'(o_tx_bus), 32'd0);
    check("mid_rst_grant", 32'(o_grant), 32'd0);
    check("mid_rst_ready", 32'(o_req_ready), 32'd0);
    check("mid_rst_start", 32'(o_tx_start), 32'd0);
    check("mid_rst_busy", 32'(o_busy), 32'd0);
    check("mid_rst_timeout", 32'(o_timeout), 32'd0);
    i_rst = 1'b0;
    mptr = 0;
    i_tx_done = 1'b1;
    tick();
    i_tx_done = 1'b0;
    check("stray_done_busy", 32'(o_busy), 32'd0);
    tick();
    check("stray_done_start", 32'(o_tx_start), 32'd0);
    add_byte(0, 8'($urandom));
    add_byte(3, 8'($urandom));
    kick(-1, found);
    active = 1'b1;

    for (int r = 0; r < 200; r++) begin
      if (!active) begin
        repeat ($urandom_range(0, 3)) begin
          i_tx_done = ($urandom_range(0, 3) == 0);
          tick();
        end
        i_tx_done = 1'b0;
        tick();
        check("idle_busy", 32'(o_busy), 32'd0);
        for (int k = 0; k < N; k++) begin
          if ($urandom_range(0, 1) == 1) begin
            repeat ($urandom_range(1, 3)) add_byte(k, 8'($urandom));
          end
        end
        add_byte(int'($urandom_range(0, N - 1)), 8'($urandom));
        kick(-1, found);
        active = 1'b1;
      end
      if ($urandom_range(0, 2) == 0) i_tx_done = 1'b1;
      tick();
      i_tx_done = 1'b0;
      repeat ($urandom_range(0, 4)) tick();
      check("wait_busy", 32'(o_busy), 32'd1);
      for (int k = 0; k < N; k++) begin
        if ($urandom_range(0, 3) == 0) add_byte(k, 8'($urandom));
      end
      do_done(-1, found);
      active = found;
    end

    while (active) begin
      tick();
      do_done(-1, found);
      active = found;
    end
    tick();
    check("scoreboard_empty", 32'(sbq.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
